rca_accumulator: RTL



---
 rtl/rca_pkg.sv | 13 +
 rtl/rca.sv | 24 ++
 rtl/rca_accumulator.sv | 113 +++++++++++
 3 files changed

// File: rtl/rca_pkg.sv
// Shared types and default sizes for the ripple-carry adder and its streaming accumulator.
package rca_pkg;

    localparam int RCA_WIDTH   = 32;
    localparam int ACC_COUNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } acc_state_t;

endpackage

// File: rtl/rca.sv
// Combinational ripple-carry adder: s = a + b mod 2^WIDTH, c = carry out of the top bit.
module rca
    import rca_pkg::*;
#(
    parameter int WIDTH = RCA_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             c
);

    logic [WIDTH:0] chain;

    assign chain[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign s[i]         = a[i] ^ b[i] ^ chain[i];
        assign chain[i + 1] = (a[i] & b[i]) | (chain[i] & (a[i] ^ b[i]));
    end

    assign c = chain[WIDTH];

endmodule

// File: rtl/rca_accumulator.sv
// Packet-reducing accumulator: sums a valid/ready operand stream through one rca and
// reports sum, sticky carry and saturating beat count when the packet closes.
module rca_accumulator
    import rca_pkg::*;
#(
    parameter int WIDTH   = RCA_WIDTH,
    parameter int COUNT_W = ACC_COUNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_sum,
    output logic               out_carry,
    output logic [COUNT_W-1:0] out_count
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
    // out_valid and its data stay asserted and stable until that edge, and in_ready
    // never depends on in_valid.
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
    localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

    acc_state_t         state;
    acc_state_t         state_next;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   sum;
    logic               sum_carry;
    logic               carry;
    logic [COUNT_W-1:0] count;
    logic               accept;

    rca #(.WIDTH(WIDTH)) u_rca (
        .a (acc),
        .b (in_data),
        .s (sum),
        .c (sum_carry)
    );

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = in_last ? DONE : ACC;
            ACC:     if (accept && in_last) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state != DONE);
        out_valid = (state == DONE);
    end

    // acc is zero in IDLE, so the adder output there is simply the first operand.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            carry <= 1'b0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc   <= sum;
                        carry <= sum_carry;
                        count <= COUNT_ONE;
                    end
                end
                ACC: begin
                    if (accept) begin
                        acc   <= sum;
                        carry <= carry | sum_carry;
                        if (count != COUNT_MAX) begin
                            count <= count + COUNT_ONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc   <= '0;
                        carry <= 1'b0;
                        count <= '0;
                    end
                end
                default: begin
                    acc   <= '0;
                    carry <= 1'b0;
                    count <= '0;
                end
            endcase
        end
    end

    assign out_sum   = acc;
    assign out_carry = carry;
    assign out_count = count;

endmodule
